// File: rtl/tx_src_switch.sv
// ---------------------------------------------------------------------------
// tx_src_switch
//
// Purpose:
//   Selects one of NCH transmit sources and forwards its data/K words to a
//   single registered output. When a different source is requested the
//   current source keeps running until it marks a safe boundary (or a drain
//   timeout expires), then GUARD idle/comma words are sent before the new
//   source is forwarded. The highest-numbered enabled source wins; channel 0
//   is the fallback when nothing is enabled.
//
// Ports:
//   TX_CLK        in   clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   SRC_EN        in   [NCH]      per-source request
//   IN_DATA       in   [NCH*DW]   source data, channel i at [i*DW +: DW]
//   IN_KCHAR      in   [NCH*KW]   source K flags, channel i at [i*KW +: KW]
//   IN_BOUNDARY   in   [NCH]      current word of channel i ends a frame
//   TX_DATA       out  [DW]       registered output data
//   TX_KCHAR      out  [KW]       registered output K flags
//   ACTIVE_SRC    out  [4]        source index aligned with TX_DATA
//   ACTIVE_VALID  out             TX_DATA carries source data
//   SWITCH_PEND   out             a switch is in progress (drain or guard)
//   SWITCH_CNT    out  [16]       completed switches, saturating
//   TIMEOUT_CNT   out  [16]       drain timeouts, saturating
// ---------------------------------------------------------------------------
module tx_src_switch #(
    parameter int                NCH       = 4,
    parameter int                DW        = 16,
    parameter logic [DW-1:0]     IDLE_DATA = 16'h3CBC,
    parameter logic [DW/8-1:0]   IDLE_K    = 2'b01,
    parameter int                GUARD     = 4,
    parameter int                DRAIN_MAX = 255
) (
    input  logic                    TX_CLK,
    input  logic                    RESET_N,
    input  logic [NCH-1:0]          SRC_EN,
    input  logic [NCH*DW-1:0]       IN_DATA,
    input  logic [NCH*(DW/8)-1:0]   IN_KCHAR,
    input  logic [NCH-1:0]          IN_BOUNDARY,
    output logic [DW-1:0]           TX_DATA,
    output logic [DW/8-1:0]         TX_KCHAR,
    output logic [3:0]              ACTIVE_SRC,
    output logic                    ACTIVE_VALID,
    output logic                    SWITCH_PEND,
    output logic [15:0]             SWITCH_CNT,
    output logic [15:0]             TIMEOUT_CNT
);

    localparam int KW = DW / 8;
    localparam logic [7:0]  GUARD_INIT = 8'(GUARD);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_GUARD
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cur_q, cur_d;
    logic [15:0]     drain_cnt_q, drain_cnt_d;
    logic [7:0]      guard_cnt_q, guard_cnt_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic [KW-1:0]   tx_kchar_q, tx_kchar_d;
    logic [3:0]      active_src_q, active_src_d;
    logic            active_valid_q, active_valid_d;
    logic            switch_pend_q, switch_pend_d;
    logic [15:0]     switch_cnt_q, switch_cnt_d;
    logic [15:0]     timeout_cnt_q, timeout_cnt_d;

    logic [3:0]      req;
    logic [DW-1:0]   cur_data;
    logic [KW-1:0]   cur_kchar;
    logic            cur_bnd;

    // Highest enabled index wins; later loop iterations override earlier ones.
    always_comb begin
        req = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SRC_EN[i]) begin
                req = 4'(i);
            end
        end
    end

    // Mux of the current channel's word and boundary flag; boundaries of
    // other channels never reach the FSM.
    always_comb begin
        cur_data  = '0;
        cur_kchar = '0;
        cur_bnd   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_q == 4'(i)) begin
                cur_data  = IN_DATA[i*DW +: DW];
                cur_kchar = IN_KCHAR[i*KW +: KW];
                cur_bnd   = IN_BOUNDARY[i];
            end
        end
    end

    // Next-state logic. Output flags describe the state that produced the
    // word, so they stay aligned with TX_DATA one cycle later.
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        drain_cnt_d    = drain_cnt_q;
        guard_cnt_d    = guard_cnt_q;
        tx_data_d      = IDLE_DATA;
        tx_kchar_d     = IDLE_K;
        active_src_d   = cur_q;
        active_valid_d = 1'b0;
        switch_pend_d  = 1'b1;
        switch_cnt_d   = switch_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;

        case (state_q)
            ST_RUN: begin
                tx_data_d      = cur_data;
                tx_kchar_d     = cur_kchar;
                active_valid_d = 1'b1;
                switch_pend_d  = 1'b0;
                if (req != cur_q) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                tx_data_d      = cur_data;
                tx_kchar_d     = cur_kchar;
                active_valid_d = 1'b1;
                // Boundary takes precedence over a withdrawn request.
                if (cur_bnd) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = GUARD_INIT;
                end else if (req == cur_q) begin
                    state_d = ST_RUN;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = GUARD_INIT;
                    if (timeout_cnt_q != 16'hFFFF) begin
                        timeout_cnt_d = timeout_cnt_q + 16'd1;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
                end
            end
            ST_GUARD: begin
                // The request is resampled only on the final idle word, so
                // request changes during the guard never lengthen it.
                if (guard_cnt_q == 8'd1) begin
                    state_d = ST_RUN;
                    cur_d   = req;
                    if (req != cur_q && switch_cnt_q != 16'hFFFF) begin
                        switch_cnt_d = switch_cnt_q + 16'd1;
                    end
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d     = ST_GUARD;
                guard_cnt_d = GUARD_INIT;
            end
        endcase
    end

    // State and output registers; reset parks the block in a full guard.
    always_ff @(posedge TX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_GUARD;
            cur_q          <= '0;
            drain_cnt_q    <= '0;
            guard_cnt_q    <= GUARD_INIT;
            tx_data_q      <= IDLE_DATA;
            tx_kchar_q     <= IDLE_K;
            active_src_q   <= '0;
            active_valid_q <= 1'b0;
            switch_pend_q  <= 1'b1;
            switch_cnt_q   <= '0;
            timeout_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            drain_cnt_q    <= drain_cnt_d;
            guard_cnt_q    <= guard_cnt_d;
            tx_data_q      <= tx_data_d;
            tx_kchar_q     <= tx_kchar_d;
            active_src_q   <= active_src_d;
            active_valid_q <= active_valid_d;
            switch_pend_q  <= switch_pend_d;
            switch_cnt_q   <= switch_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

    assign TX_DATA      = tx_data_q;
    assign TX_KCHAR     = tx_kchar_q;
    assign ACTIVE_SRC   = active_src_q;
    assign ACTIVE_VALID = active_valid_q;
    assign SWITCH_PEND  = switch_pend_q;
    assign SWITCH_CNT   = switch_cnt_q;
    assign TIMEOUT_CNT  = timeout_cnt_q;

endmodule

// File: tb/tb_tx_src_switch.sv
// ---------------------------------------------------------------------------
// tb_tx_src_switch
//
// Purpose:
//   Self-checking bench for tx_src_switch with default parameters. A table of
//   per-cycle vectors covers start-up, a boundary switch, withdrawal and
//   boundary-beats-withdrawal; hand sequences cover the drain timeout, reset
//   in the middle of a guard and request changes during a guard; a random
//   phase compares against a behavioural model of the switching rules.
// ---------------------------------------------------------------------------
module tb_tx_src_switch;

    localparam int          NCH       = 4;
    localparam int          GUARD     = 4;
    localparam int          DRAIN_MAX = 255;
    localparam logic [15:0] IDL       = 16'h3CBC;
    localparam logic [15:0] D0        = 16'hA000;
    localparam logic [15:0] D1        = 16'hA111;
    localparam logic [15:0] D2        = 16'hA222;
    localparam logic [15:0] D3        = 16'hA333;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src_en;
    logic [63:0] in_data;
    logic [7:0]  in_kchar;
    logic [3:0]  in_boundary;
    logic [15:0] tx_data;
    logic [1:0]  tx_kchar;
    logic [3:0]  active_src;
    logic        active_valid;
    logic        switch_pend;
    logic [15:0] switch_cnt;
    logic [15:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    tx_src_switch dut (
        .TX_CLK       (clk),
        .RESET_N      (rst_n),
        .SRC_EN       (src_en),
        .IN_DATA      (in_data),
        .IN_KCHAR     (in_kchar),
        .IN_BOUNDARY  (in_boundary),
        .TX_DATA      (tx_data),
        .TX_KCHAR     (tx_kchar),
        .ACTIVE_SRC   (active_src),
        .ACTIVE_VALID (active_valid),
        .SWITCH_PEND  (switch_pend),
        .SWITCH_CNT   (switch_cnt),
        .TIMEOUT_CNT  (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  src_en;
        logic [3:0]  bnd;
        logic [15:0] e_data;
        logic [1:0]  e_k;
        logic [3:0]  e_src;
        logic        e_valid;
        logic        e_pend;
        logic [15:0] e_sw;
        logic [15:0] e_to;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: a switch is "waiting" for a boundary, or is busy
    // sending idle words; otherwise the current source simply streams out.
    int          m_cur;
    int          m_idle_left;
    bit          m_waiting;
    int          m_waited;
    int          m_sw;
    int          m_to;
    logic [15:0] m_data;
    logic [1:0]  m_k;
    logic [3:0]  m_src;
    logic        m_valid;
    logic        m_pend;

    task automatic add_vec(input logic [3:0] s, input logic [3:0] b,
                           input logic [15:0] d, input logic [1:0] k,
                           input logic [3:0] src, input logic v,
                           input logic p, input logic [15:0] sw,
                           input logic [15:0] to);
        vec_t r;
        r.src_en = s; r.bnd = b; r.e_data = d; r.e_k = k; r.e_src = src;
        r.e_valid = v; r.e_pend = p; r.e_sw = sw; r.e_to = to;
        vecs.push_back(r);
    endtask

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic [15:0] d,
                                input logic [1:0] k, input logic [3:0] src,
                                input logic v, input logic p,
                                input logic [15:0] sw, input logic [15:0] to);
        check_val({tag, ".data"},  32'(tx_data),      32'(d));
        check_val({tag, ".kchar"}, 32'(tx_kchar),     32'(k));
        check_val({tag, ".src"},   32'(active_src),   32'(src));
        check_val({tag, ".valid"}, 32'(active_valid), 32'(v));
        check_val({tag, ".pend"},  32'(switch_pend),  32'(p));
        check_val({tag, ".swcnt"}, 32'(switch_cnt),   32'(sw));
        check_val({tag, ".tocnt"}, 32'(timeout_cnt),  32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int req_of(input logic [3:0] en);
        for (int i = NCH - 1; i > 0; i--) begin
            if (en[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_idle_left = GUARD; m_waiting = 0; m_waited = 0;
        m_sw = 0; m_to = 0;
        m_data = IDL; m_k = 2'b01; m_src = 0; m_valid = 0; m_pend = 1;
    endtask

    // Called right after a rising edge with the inputs that edge sampled.
    task automatic model_step();
        int r;
        r = req_of(src_en);
        m_src = 4'(m_cur);
        if (m_idle_left > 0) begin
            m_data = IDL; m_k = 2'b01; m_valid = 0; m_pend = 1;
            m_idle_left--;
            if (m_idle_left == 0) begin
                if (r != m_cur && m_sw < 65535) m_sw++;
                m_cur = r;
            end
        end else begin
            m_data  = in_data[m_cur*16 +: 16];
            m_k     = in_kchar[m_cur*2 +: 2];
            m_valid = 1;
            m_pend  = m_waiting;
            if (m_waiting) begin
                if (in_boundary[m_cur]) begin
                    m_waiting = 0; m_idle_left = GUARD;
                end else if (r == m_cur) begin
                    m_waiting = 0;
                end else begin
                    m_waited++;
                    if (m_waited == DRAIN_MAX) begin
                        m_waiting = 0; m_idle_left = GUARD;
                        if (m_to < 65535) m_to++;
                    end
                end
            end else if (r != m_cur) begin
                m_waiting = 1; m_waited = 0;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] s, input logic [3:0] b);
        src_en      = s;
        in_boundary = b;
    endtask

    task automatic set_fixed_data();
        in_data  = {D3, D2, D1, D0};
        in_kchar = {2'b11, 2'b10, 2'b01, 2'b00};
    endtask

    // Safety net so the run always ends on its own.
    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        // Start-up, boundary switch 0->2, withdrawal, boundary beats withdrawal.
        for (int i = 0; i < 3; i++) add_vec(4'b0000, 4'b0000, IDL, 2'b01, 0, 0, 1, 0, 0);
        add_vec(4'b0000, 4'b0000, IDL, 2'b01, 0, 0, 1, 0, 0);
        add_vec(4'b0000, 4'b0000, D0, 2'b00, 0, 1, 0, 0, 0);
        add_vec(4'b0000, 4'b0000, D0, 2'b00, 0, 1, 0, 0, 0);
        add_vec(4'b0100, 4'b0000, D0, 2'b00, 0, 1, 0, 0, 0);
        add_vec(4'b0100, 4'b0000, D0, 2'b00, 0, 1, 1, 0, 0);
        add_vec(4'b0100, 4'b0100, D0, 2'b00, 0, 1, 1, 0, 0);
        add_vec(4'b0100, 4'b0000, D0, 2'b00, 0, 1, 1, 0, 0);
        add_vec(4'b0100, 4'b0000, D0, 2'b00, 0, 1, 1, 0, 0);
        add_vec(4'b0100, 4'b0001, D0, 2'b00, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add_vec(4'b0100, 4'b0000, IDL, 2'b01, 0, 0, 1, 0, 0);
        add_vec(4'b0100, 4'b0000, IDL, 2'b01, 0, 0, 1, 1, 0);
        add_vec(4'b0100, 4'b0000, D2, 2'b10, 2, 1, 0, 1, 0);
        add_vec(4'b1100, 4'b0000, D2, 2'b10, 2, 1, 0, 1, 0);
        add_vec(4'b0100, 4'b0000, D2, 2'b10, 2, 1, 1, 1, 0);
        add_vec(4'b0100, 4'b0000, D2, 2'b10, 2, 1, 0, 1, 0);
        add_vec(4'b1100, 4'b0000, D2, 2'b10, 2, 1, 0, 1, 0);
        add_vec(4'b0100, 4'b0100, D2, 2'b10, 2, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) add_vec(4'b0100, 4'b0000, IDL, 2'b01, 2, 0, 1, 1, 0);
        add_vec(4'b0100, 4'b0000, D2, 2'b10, 2, 1, 0, 1, 0);

        rst_n = 1'b0;
        apply_stimulus(4'b0000, 4'b0000);
        set_fixed_data();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset", IDL, 2'b01, 0, 0, 1, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].src_en, vecs[i].bnd);
            tick();
            check_output($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_k,
                         vecs[i].e_src, vecs[i].e_valid, vecs[i].e_pend,
                         vecs[i].e_sw, vecs[i].e_to);
        end

        // Drain timeout: ch2 never marks a boundary while ch3 is requested.
        apply_stimulus(4'b1100, 4'b0000);
        tick();
        check_output("to_enter", D2, 2'b10, 2, 1, 0, 1, 0);
        for (int k = 1; k <= DRAIN_MAX; k++) begin
            tick();
            check_val($sformatf("to_drain%0d.data", k), 32'(tx_data), 32'(D2));
            check_val($sformatf("to_drain%0d.pend", k), 32'(switch_pend), 32'd1);
            check_val($sformatf("to_drain%0d.tocnt", k), 32'(timeout_cnt),
                      (k == DRAIN_MAX) ? 32'd1 : 32'd0);
        end
        for (int k = 1; k <= GUARD; k++) begin
            tick();
            check_output($sformatf("to_idle%0d", k), IDL, 2'b01, 2, 0, 1,
                         (k == GUARD) ? 16'd2 : 16'd1, 1);
        end
        tick();
        check_output("to_run3", D3, 2'b11, 3, 1, 0, 2, 1);

        // Reset asserted in the second guard cycle.
        apply_stimulus(4'b0000, 4'b0000);
        tick();
        check_output("rg_enter", D3, 2'b11, 3, 1, 0, 2, 1);
        apply_stimulus(4'b0000, 4'b1000);
        tick();
        check_output("rg_bnd", D3, 2'b11, 3, 1, 1, 2, 1);
        apply_stimulus(4'b0000, 4'b0000);
        tick();
        check_output("rg_idle1", IDL, 2'b01, 3, 0, 1, 2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rg_async", IDL, 2'b01, 0, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= GUARD; k++) begin
            tick();
            check_output($sformatf("rg_idle%0d", k), IDL, 2'b01, 0, 0, 1, 0, 0);
        end
        tick();
        check_output("rg_run0", D0, 2'b00, 0, 1, 0, 0, 0);

        // Request moves from ch1 to ch3 during the guard.
        apply_stimulus(4'b0010, 4'b0000);
        tick();
        check_output("gc_enter", D0, 2'b00, 0, 1, 0, 0, 0);
        apply_stimulus(4'b0010, 4'b0001);
        tick();
        check_output("gc_bnd", D0, 2'b00, 0, 1, 1, 0, 0);
        apply_stimulus(4'b0010, 4'b0000);
        tick();
        check_output("gc_idle1", IDL, 2'b01, 0, 0, 1, 0, 0);
        apply_stimulus(4'b1000, 4'b0000);
        for (int k = 2; k <= GUARD; k++) begin
            tick();
            check_output($sformatf("gc_idle%0d", k), IDL, 2'b01, 0, 0, 1,
                         (k == GUARD) ? 16'd1 : 16'd0, 0);
        end
        tick();
        check_output("gc_run3", D3, 2'b11, 3, 1, 0, 1, 0);

        // Random phase against the behavioural model.
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("rnd_reset", m_data, m_k, m_src, m_valid, m_pend,
                     16'(m_sw), 16'(m_to));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_output($sformatf("rnd%0d_rst", c), m_data, m_k, m_src,
                             m_valid, m_pend, 16'(m_sw), 16'(m_to));
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                continue;
            end
            in_data  = {$urandom, $urandom};
            in_kchar = 8'($urandom);
            if ($urandom_range(0, 5) == 0) src_en = 4'($urandom);
            if ((c % 800) >= 400) begin
                in_boundary = 4'b0000;
            end else begin
                in_boundary = 4'($urandom) & 4'($urandom) & 4'($urandom);
            end
            @(posedge clk);
            model_step();
            #1;
            check_output($sformatf("rnd%0d", c), m_data, m_k, m_src, m_valid,
                         m_pend, 16'(m_sw), 16'(m_to));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
